branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- Consumer/trainer side of the gshare predictor interface.
- Captures each issued prediction (pc, history snapshot, predicted direction) in an in-order queue.
- Retires entries against actual outcomes from the execute stage and drives the predictor's training interface: train_valid, train_taken, train_mispredicted, train_history, train_pc.
- On a misprediction, discards all younger wrong-path entries and raises a flush.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 2.
- PC_W, 7, branch PC width; equals the PHT index width.
- HIST_W, 7, global history width; equals PC_W.
- CNT_W, 16, statistics counter width; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enq_valid  in  1  prediction issued this cycle; wire to the predictor's predict_valid.
- enq_pc  in  PC_W  PC of the predicted branch.
- enq_history  in  HIST_W  predictor's predict_history at prediction time.
- enq_pred_taken  in  1  predictor's predict_taken.
- enq_ready  out  1  queue not full and not flushing.
- resolve_valid  in  1  oldest outstanding branch resolved.
- resolve_taken  in  1  actual direction.
- resolve_ready  out  1  queue not empty.
- train_valid  out  1  one-cycle training strobe.
- train_taken  out  1  actual direction of the retired entry.
- train_mispredicted  out  1  actual direction differs from predicted.
- train_history  out  HIST_W  stored history of the retired entry.
- train_pc  out  PC_W  stored PC of the retired entry.
- flush  out  1  wrong-path flush pulse.
- count  out  $clog2(DEPTH)+1  current occupancy.
- stat_resolved  out  CNT_W  resolved-branch count (optional feature).
- stat_mispred  out  CNT_W  misprediction count (optional feature).

Behaviour:
- Reset (rst=1 at a clk edge) clears head, tail and count, and forces state=RUN.
- Reset values: all train_* outputs 0, flush=0, enq_ready=1, resolve_ready=0, stat_* = 0.
- Reset has priority over everything, including mid-flush; the queue contents are don't-care after reset.
- State machine, 2 states:
  - RUN: normal operation.
  - FLUSH: entered for exactly one cycle after a mispredict; always returns to RUN.
- enq_ready = (state==RUN) && (count!=DEPTH); it is a registered-state function, not combinational on resolve.
- Enqueue: when enq_valid && enq_ready, write {pc, history, pred_taken} at tail; tail increments modulo DEPTH.
- enq_valid while not ready: the request is dropped silently; no state change.
- resolve_ready = (count!=0).
- Resolve: when resolve_valid && resolve_ready, pop the head. resolve_valid while empty is ignored; no train strobe.
- Training outputs are registered, one-cycle latency: resolve accepted in cycle T gives train_valid=1 in T+1 with:
  - train_taken = resolve_taken
  - train_mispredicted = resolve_taken ^ stored pred_taken
  - train_pc, train_history = the stored values
  - train_valid is 0 in every other cycle. The train_* data fields hold their last value when train_valid=0.
- Mispredict accepted in cycle T:
  - At the T edge: head, tail and count clear, so all younger entries are dropped. Any enqueue offered in T is also dropped as wrong-path.
  - Go to FLUSH; flush=1 during T+1, coincident with train_mispredicted=1.
  - enq_ready=0 in T+1, because the predictor restores its GHR at the end of T+1. Enqueues resume in T+2.
- Correct resolve with a simultaneous enqueue in the same cycle: both occur and count is unchanged.
- Full queue with resolve and enq_valid in the same cycle: the enqueue is refused (enq_ready already 0); the pop proceeds.
- Pointer wrap: head and tail wrap DEPTH-1 to 0. Full and empty are distinguished by count, not by pointer compare.

Optional Feature:
- Macro BRQ_STATS_EN.
- Defined:
  - stat_resolved increments on each accepted resolve.
  - stat_mispred increments on each mispredicted resolve.
  - Both saturate at all-ones and clear on rst.
- Undefined: counter logic is absent and both outputs are tied to 0.

Decomposition:
- Shared package bp_pkg holds:
  - localparams PC_W=7 and HIST_W=7 shared with the predictor.
  - typedef bp_entry_t = {pc, history, pred_taken}.
  - state enum {RUN, FLUSH}.
- Sub-module brq_storage: DEPTH x bp_entry_t register array, one write port and one read port. The top keeps pointers, count, FSM and training registers.

Test Plan:
- Reset then enqueue 3 entries, e.g. (pc=0x05, hist=0x00, pred=0), then resolve 3 times all matching predictions -> three train_valid pulses, each one cycle after its resolve. train_mispredicted=0 and pc/history are returned in order. count goes 3,2,1,0; resolve_ready=0 at the end.
- Fill to DEPTH=8 -> enq_ready=0. A 9th enq_valid is dropped and count stays 8. One resolve -> count 7, and enq_ready=1 the next cycle.
- Enqueue 4 entries; resolve the head with the opposite direction (pred=1, actual=0) while enq_valid=1 -> next cycle train_mispredicted=1, train_taken=0 and flush=1 for one cycle. count=0, and the same-cycle enqueue is lost. enq_ready=0 during the flush, then 1.
- Run 20 enqueue/resolve pairs with DEPTH=8 -> pointers wrap. Order is preserved and the training PCs match the enqueued PCs 0x00..0x13.
- Assert rst while count=5 and during a FLUSH cycle -> next cycle count=0, flush=0, train_valid=0, enq_ready=1.
- With BRQ_STATS_EN and CNT_W=4: 20 resolves including 3 mispredicts -> stat_resolved saturates at 15 and stat_mispred=3. Without the macro, both outputs read 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Package shared by the gshare predictor and its branch resolve queue.
// Holds the predictor widths, the queued prediction record and the queue FSM states.
package bp_pkg;

    localparam int unsigned PC_W   = 7;
    localparam int unsigned HIST_W = 7;

    // One issued prediction, as captured at predict time.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] history;
        logic              pred_taken;
    } bp_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } brq_state_e;

endpackage

// File: rtl/brq_storage.sv
// brq_storage: DEPTH x bp_entry_t register array for the branch resolve queue.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable
//   waddr - write index
//   wdata - entry to write
//   raddr - read index (combinational read)
//   rdata - entry at raddr
// Contents are not reset; occupancy is tracked by the owner.
module brq_storage
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  bp_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output bp_entry_t                rdata
);

    bp_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of issued gshare predictions. Retires entries
// against resolved outcomes, drives the predictor training interface, and on a
// mispredict drops all younger (wrong-path) entries and pulses flush for one cycle.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   enq_valid/pc/history/pred_taken, enq_ready  - prediction capture
//   resolve_valid/taken, resolve_ready          - oldest branch outcome
//   train_valid/taken/mispredicted/history/pc   - registered training strobe + data
//   flush                         - one-cycle wrong-path flush
//   count                         - occupancy
//   stat_resolved, stat_mispred   - statistics counters
// Optional feature: define BRQ_STATS_EN to build the saturating statistics counters;
// otherwise the stat outputs are tied to 0.
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PC_W   = bp_pkg::PC_W,
    parameter int unsigned HIST_W = bp_pkg::HIST_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [PC_W-1:0]          enq_pc,
    input  logic [HIST_W-1:0]        enq_history,
    input  logic                     enq_pred_taken,
    output logic                     enq_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     resolve_ready,
    output logic                     train_valid,
    output logic                     train_taken,
    output logic                     train_mispredicted,
    output logic [HIST_W-1:0]        train_history,
    output logic [PC_W-1:0]          train_pc,
    output logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stat_resolved,
    output logic [CNT_W-1:0]         stat_mispred
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;
    brq_state_e       state_q, state_d;
    bp_entry_t        wr_entry, rd_entry;
    logic             enq_fire, res_fire, mispredict;

    assign enq_ready     = (state_q == RUN) && (count_q != FULL);
    assign resolve_ready = (count_q != '0);
    assign enq_fire      = enq_valid && enq_ready;
    assign res_fire      = resolve_valid && resolve_ready;
    assign mispredict    = res_fire && (resolve_taken != rd_entry.pred_taken);
    assign flush         = (state_q == FLUSH);
    assign count         = count_q;

    assign wr_entry = '{pc: enq_pc, history: enq_history, pred_taken: enq_pred_taken};

    brq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        // A same-cycle enqueue during a mispredict is wrong-path; don't write it.
        .we    (enq_fire && !mispredict),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (rd_entry)
    );

    // Pointer/occupancy next state. Full vs empty is told apart by count only.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (res_fire) head_d = head_q + PTR_W'(1);
            if (enq_fire) tail_d = tail_q + PTR_W'(1);
            case ({enq_fire, res_fire})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FLUSH lasts exactly one cycle so the predictor can restore its GHR.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (mispredict) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Training outputs: data fields hold when no resolve is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            train_valid        <= 1'b0;
            train_taken        <= 1'b0;
            train_mispredicted <= 1'b0;
            train_history      <= '0;
            train_pc           <= '0;
        end else begin
            train_valid <= res_fire;
            if (res_fire) begin
                train_taken        <= resolve_taken;
                train_mispredicted <= mispredict;
                train_history      <= rd_entry.history;
                train_pc           <= rd_entry.pc;
            end
        end
    end

`ifdef BRQ_STATS_EN
    logic [CNT_W-1:0] stat_resolved_q, stat_mispred_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (res_fire && (stat_resolved_q != '1)) stat_resolved_q <= stat_resolved_q + 1'b1;
            if (mispredict && (stat_mispred_q != '1)) stat_mispred_q <= stat_mispred_q + 1'b1;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`else
    assign stat_resolved = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

    localparam int DEPTH  = 8;
    localparam int PC_W   = 7;
    localparam int HIST_W = 7;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enq_valid = 1'b0;
    logic [PC_W-1:0]   enq_pc = '0;
    logic [HIST_W-1:0] enq_history = '0;
    logic              enq_pred_taken = 1'b0;
    logic              enq_ready;
    logic              resolve_valid = 1'b0;
    logic              resolve_taken = 1'b0;
    logic              resolve_ready;
    logic              train_valid, train_taken, train_mispredicted;
    logic [HIST_W-1:0] train_history;
    logic [PC_W-1:0]   train_pc;
    logic              flush;
    logic [3:0]        count;
    logic [CNT_W-1:0]  stat_resolved, stat_mispred;

    always #5 clk = ~clk;

    branch_resolve_queue #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .HIST_W (HIST_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enq_valid          (enq_valid),
        .enq_pc             (enq_pc),
        .enq_history        (enq_history),
        .enq_pred_taken     (enq_pred_taken),
        .enq_ready          (enq_ready),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .resolve_ready      (resolve_ready),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .train_history      (train_history),
        .train_pc           (train_pc),
        .flush              (flush),
        .count              (count),
        .stat_resolved      (stat_resolved),
        .stat_mispred       (stat_mispred)
    );

    int checks = 0;
    int fails  = 0;

    // Behavioural model: a FIFO of outstanding predictions plus expected outputs.
    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] hist;
        logic              pred;
    } ment_t;

    ment_t             mq[$];
    bit                m_flush;
    int                m_res, m_mis;
    logic              exp_tv, exp_tt, exp_tm;
    logic [HIST_W-1:0] exp_th;
    logic [PC_W-1:0]   exp_tpc;
    int                exp_sr, exp_sm;

    task automatic update_stats();
`ifdef BRQ_STATS_EN
        exp_sr = (m_res > 15) ? 15 : m_res;
        exp_sm = (m_mis > 15) ? 15 : m_mis;
`else
        exp_sr = 0;
        exp_sm = 0;
`endif
    endtask

    // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input bit ev, input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] hist,
                         input bit pt, input bit rv, input bit rt);
        bit    e_ok, r_ok, mis;
        ment_t h;
        enq_valid      = ev;
        enq_pc         = pc;
        enq_history    = hist;
        enq_pred_taken = pt;
        resolve_valid  = rv;
        resolve_taken  = rt;
        e_ok = ev && !m_flush && (mq.size() < DEPTH);
        r_ok = rv && (mq.size() > 0);
        mis  = 1'b0;
        exp_tv = r_ok;
        if (r_ok) begin
            h       = mq.pop_front();
            mis     = (rt != h.pred);
            exp_tt  = rt;
            exp_tm  = mis;
            exp_th  = h.hist;
            exp_tpc = h.pc;
            m_res++;
            if (mis) m_mis++;
        end
        if (mis) mq.delete();
        else if (e_ok) mq.push_back('{pc: pc, hist: hist, pred: pt});
        m_flush = mis;
        update_stats();
        @(posedge clk);
        #1;
        enq_valid     = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic enq(input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] hist, input bit pt);
        cycle(1'b1, pc, hist, pt, 1'b0, 1'b0);
    endtask

    task automatic res(input bit rt);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, rt);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        enq_valid     = 1'b0;
        resolve_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_flush = 1'b0;
        m_res = 0;
        m_mis = 0;
        exp_tv = 0; exp_tt = 0; exp_tm = 0; exp_th = '0; exp_tpc = '0;
        update_stats();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (train_valid !== 1'b0) begin fails++; $display("FAIL rst_tv got %b exp 0", train_valid); end
        checks++; if ({train_taken, train_mispredicted, train_history, train_pc} !== '0) begin
            fails++; $display("FAIL rst_tdata got %0h exp 0", {train_taken, train_mispredicted, train_history, train_pc}); end
        checks++; if (flush !== 1'b0) begin fails++; $display("FAIL rst_flush got %b exp 0", flush); end
        checks++; if (enq_ready !== 1'b1) begin fails++; $display("FAIL rst_enq_ready got %b exp 1", enq_ready); end
        checks++; if (resolve_ready !== 1'b0) begin fails++; $display("FAIL rst_res_ready got %b exp 0", resolve_ready); end
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if ({stat_resolved, stat_mispred} !== '0) begin fails++; $display("FAIL rst_stats got %0h exp 0", {stat_resolved, stat_mispred}); end
    endtask

    task automatic test_in_order();
        logic [PC_W-1:0]   pcs [3];
        logic [HIST_W-1:0] hs  [3];
        bit                ps  [3];
        pcs = '{7'h05, 7'h0A, 7'h13};
        hs  = '{7'h00, 7'h11, 7'h22};
        ps  = '{1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) enq(pcs[i], hs[i], ps[i]);
        checks++; if (count !== 4'd3) begin fails++; $display("FAIL io_count3 got %0d exp 3", count); end
        for (int i = 0; i < 3; i++) begin
            res(ps[i]);
            checks++; if (train_valid !== 1'b1 || train_mispredicted !== 1'b0) begin
                fails++; $display("FAIL io_train%0d got v=%b m=%b exp v=1 m=0", i, train_valid, train_mispredicted); end
            checks++; if (train_pc !== pcs[i] || train_history !== hs[i] || train_taken !== ps[i]) begin
                fails++; $display("FAIL io_data%0d got pc=%0h h=%0h t=%b exp pc=%0h h=%0h t=%b",
                                  i, train_pc, train_history, train_taken, pcs[i], hs[i], ps[i]); end
            checks++; if (count !== 4'(2 - i)) begin fails++; $display("FAIL io_count got %0d exp %0d", count, 2 - i); end
        end
        checks++; if (resolve_ready !== 1'b0) begin fails++; $display("FAIL io_res_ready got %b exp 0", resolve_ready); end
        // Resolve on empty queue is ignored.
        res(1'b1);
        checks++; if (train_valid !== 1'b0 || count !== 4'd0) begin
            fails++; $display("FAIL io_empty_res got v=%b c=%0d exp v=0 c=0", train_valid, count); end
        checks++; if (train_pc !== 7'h13) begin fails++; $display("FAIL io_hold got %0h exp 13", train_pc); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) enq(7'(i + 32), 7'(i), 1'b1);
        checks++; if (enq_ready !== 1'b0 || count !== 4'd8) begin
            fails++; $display("FAIL full_state got rdy=%b c=%0d exp rdy=0 c=8", enq_ready, count); end
        enq(7'h7F, 7'h7F, 1'b1);
        checks++; if (count !== 4'd8) begin fails++; $display("FAIL full_drop got %0d exp 8", count); end
        cycle(1'b1, 7'h7E, 7'h7E, 1'b1, 1'b1, 1'b1);
        checks++; if (count !== 4'd7 || enq_ready !== 1'b1) begin
            fails++; $display("FAIL full_pop got c=%0d rdy=%b exp c=7 rdy=1", count, enq_ready); end
        checks++; if (train_pc !== 7'd32) begin fails++; $display("FAIL full_pop_pc got %0h exp 20", train_pc); end
        // Drain and confirm the refused enqueue never entered.
        for (int i = 1; i < DEPTH; i++) begin
            res(1'b1);
            checks++; if (train_pc !== 7'(i + 32)) begin fails++; $display("FAIL full_drain got %0h exp %0h", train_pc, i + 32); end
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 4; i++) enq(7'(i + 1), 7'(i + 64), 1'b1);
        cycle(1'b1, 7'h55, 7'h55, 1'b0, 1'b1, 1'b0);
        checks++; if (train_valid !== 1'b1 || train_mispredicted !== 1'b1 || train_taken !== 1'b0) begin
            fails++; $display("FAIL mp_train got v=%b m=%b t=%b exp 1 1 0", train_valid, train_mispredicted, train_taken); end
        checks++; if (flush !== 1'b1 || count !== 4'd0 || enq_ready !== 1'b0) begin
            fails++; $display("FAIL mp_flush got f=%b c=%0d rdy=%b exp f=1 c=0 rdy=0", flush, count, enq_ready); end
        enq(7'h66, 7'h66, 1'b0);  // offered during flush: dropped
        checks++; if (flush !== 1'b0 || enq_ready !== 1'b1 || train_valid !== 1'b0 || count !== 4'd0) begin
            fails++; $display("FAIL mp_after got f=%b rdy=%b v=%b c=%0d exp 0 1 0 0", flush, enq_ready, train_valid, count); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            enq(7'(i), 7'(i ^ 7'h2A), i[0]);
            res(i[0]);
            checks++; if (train_valid !== 1'b1 || train_pc !== 7'(i) || train_history !== 7'(i ^ 7'h2A)) begin
                fails++; $display("FAIL wrap%0d got v=%b pc=%0h h=%0h exp v=1 pc=%0h h=%0h",
                                  i, train_valid, train_pc, train_history, i, i ^ 7'h2A); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) enq(7'(i), 7'(i), 1'b0);
        checks++; if (count !== 4'd5) begin fails++; $display("FAIL rm_count got %0d exp 5", count); end
        do_reset();
        checks++; if (count !== 4'd0 || flush !== 1'b0 || train_valid !== 1'b0 || enq_ready !== 1'b1) begin
            fails++; $display("FAIL rm_cnt5 got c=%0d f=%b v=%b rdy=%b exp 0 0 0 1", count, flush, train_valid, enq_ready); end
        enq(7'h01, 7'h01, 1'b1);
        enq(7'h02, 7'h02, 1'b1);
        res(1'b0);
        checks++; if (flush !== 1'b1) begin fails++; $display("FAIL rm_inflush got %b exp 1", flush); end
        do_reset();
        checks++; if (count !== 4'd0 || flush !== 1'b0 || train_valid !== 1'b0 || enq_ready !== 1'b1) begin
            fails++; $display("FAIL rm_flush got c=%0d f=%b v=%b rdy=%b exp 0 0 0 1", count, flush, train_valid, enq_ready); end
    endtask

    task automatic test_stats();
        bit pt, mis;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            pt  = i[1];
            mis = (i == 3) || (i == 9) || (i == 15);
            enq(7'(i), 7'(i), pt);
            res(pt ^ mis);
            if (mis) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        end
`ifdef BRQ_STATS_EN
        checks++; if (stat_resolved !== 4'd15) begin fails++; $display("FAIL stat_res got %0d exp 15", stat_resolved); end
        checks++; if (stat_mispred !== 4'd3) begin fails++; $display("FAIL stat_mis got %0d exp 3", stat_mispred); end
`else
        checks++; if (stat_resolved !== 4'd0) begin fails++; $display("FAIL stat_res got %0d exp 0", stat_resolved); end
        checks++; if (stat_mispred !== 4'd0) begin fails++; $display("FAIL stat_mis got %0d exp 0", stat_mispred); end
`endif
    endtask

    task automatic test_random();
        bit ev, rv, rt;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ev = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 2) == 0);
            rt = $urandom_range(0, 1);
            if (mq.size() > 0) rt = ($urandom_range(0, 7) == 0) ? !mq[0].pred : mq[0].pred;
            cycle(ev, 7'($urandom), 7'($urandom), 1'($urandom), rv, rt);
            checks++; if (train_valid !== exp_tv || train_taken !== exp_tt || train_mispredicted !== exp_tm) begin
                fails++; $display("FAIL rnd_train@%0d got v=%b t=%b m=%b exp %b %b %b",
                                  n, train_valid, train_taken, train_mispredicted, exp_tv, exp_tt, exp_tm); end
            checks++; if (train_pc !== exp_tpc || train_history !== exp_th) begin
                fails++; $display("FAIL rnd_data@%0d got pc=%0h h=%0h exp pc=%0h h=%0h",
                                  n, train_pc, train_history, exp_tpc, exp_th); end
            checks++; if (count !== 4'(mq.size()) || flush !== m_flush) begin
                fails++; $display("FAIL rnd_occ@%0d got c=%0d f=%b exp c=%0d f=%b", n, count, flush, mq.size(), m_flush); end
            checks++; if (enq_ready !== (!m_flush && mq.size() < DEPTH) || resolve_ready !== (mq.size() > 0)) begin
                fails++; $display("FAIL rnd_ready@%0d got e=%b r=%b", n, enq_ready, resolve_ready); end
            checks++; if (stat_resolved !== 4'(exp_sr) || stat_mispred !== 4'(exp_sm)) begin
                fails++; $display("FAIL rnd_stats@%0d got %0d/%0d exp %0d/%0d", n, stat_resolved, stat_mispred, exp_sr, exp_sm); end
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_mispredict();
        test_wrap();
        test_reset_mid();
        test_stats();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
